infix_to_postfix: RTL and testbench

Shunting-yard front end of the expression calculator. Accepts an infix token stream (8-bit numbers and ASCII operators `+ - * / ( )`) through a valid/ready handshake and emits the equivalent postfix stream as single-cycle number/sign strobes. It sits directly upstream of the postfix stack evaluator and drives its NUMBER/SIGN strobe inputs, observing its BUSY.

---
 rtl/itp_pkg.sv | 45 ++++
 rtl/infix_to_postfix_if.sv | 26 ++
 rtl/itp_op_stack.sv | 44 ++++
 rtl/infix_to_postfix.sv | 195 +++++++++++++++++++
 tb/tb_infix_to_postfix.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/itp_pkg.sv
// itp_pkg: shared definitions for the infix-to-postfix front end.
//   - ASCII token constants for the supported operators
//   - FSM state encoding
//   - prec(): operator precedence used by the shunting-yard reduce step
//   - END_MARK_VAL: payload driven on both buses with the end-of-expression marker
// Optional feature macro: ITP_PAREN_EN (parenthesis support; removes ST_CLOSE when undefined).
package itp_pkg;

  localparam logic [7:0] TOK_ADD    = 8'h2B;  // '+'
  localparam logic [7:0] TOK_SUB    = 8'h2D;  // '-'
  localparam logic [7:0] TOK_MUL    = 8'h2A;  // '*'
  localparam logic [7:0] TOK_DIV    = 8'h2F;  // '/'
  localparam logic [7:0] TOK_LPAREN = 8'h28;  // '('
  localparam logic [7:0] TOK_RPAREN = 8'h29;  // ')'

  localparam logic [7:0] END_MARK_VAL = 8'h00;

  typedef enum logic [2:0] {
    ST_ACCEPT   = 3'd0,
    ST_EMIT_NUM = 3'd1,
    ST_REDUCE   = 3'd2,
    ST_PUSH_OP  = 3'd3,
`ifdef ITP_PAREN_EN
    ST_CLOSE    = 3'd4,
`endif
    ST_DRAIN    = 3'd5,
    ST_END_MARK = 3'd6,
    ST_FLUSH    = 3'd7
  } state_t;

  function automatic logic is_arith(input logic [7:0] c);
    return (c == TOK_ADD) || (c == TOK_SUB) || (c == TOK_MUL) || (c == TOK_DIV);
  endfunction

  // '(' falls into the default: precedence 0 means no arithmetic operator
  // ever pops it during a reduce.
  function automatic logic [1:0] prec(input logic [7:0] c);
    case (c)
      TOK_MUL, TOK_DIV: prec = 2'd2;
      TOK_ADD, TOK_SUB: prec = 2'd1;
      default:          prec = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/infix_to_postfix_if.sv
// infix_to_postfix_if: token input handshake, downstream strobe outputs and error flag.
//   master : token source / downstream side (drives IN_*, DOWN_BUSY)
//   slave  : infix_to_postfix (drives IN_READY, OUT_*, *_STB, ERR)
interface infix_to_postfix_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic       IN_IS_NUM;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic       DOWN_BUSY;
  logic [7:0] OUT_NUMBER;
  logic       NUMBER_STB;
  logic [7:0] OUT_SIGN;
  logic       SIGN_STB;
  logic       ERR;

  modport master (
    output IN_VALID, IN_IS_NUM, IN_DATA, IN_LAST, DOWN_BUSY,
    input  IN_READY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, ERR
  );

  modport slave (
    input  IN_VALID, IN_IS_NUM, IN_DATA, IN_LAST, DOWN_BUSY,
    output IN_READY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, ERR
  );
endinterface

// File: rtl/itp_op_stack.sv
// itp_op_stack: LIFO of DEPTH x 8-bit operator codes.
//   CLK, RST   : clock, synchronous active-high reset (empties the stack)
//   clr        : synchronous clear
//   push/pop   : one operation per cycle; push on full and pop on empty are ignored
//   push_data  : value written on push
//   top        : current top entry (8'h00 when empty)
//   empty/full : occupancy flags
module itp_op_stack #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] top,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0][7:0] mem;
  logic [AW:0]           cnt;
  logic [AW-1:0]         top_idx;

  // Wraps to DEPTH-1 when full, which is exactly the top slot.
  assign top_idx = cnt[AW-1:0] - 1'b1;
  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign top     = empty ? 8'h00 : mem[top_idx];

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[cnt[AW-1:0]] <= push_data;
      cnt              <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/infix_to_postfix.sv
// infix_to_postfix: shunting-yard converter. Takes infix tokens over a valid/ready
// handshake and issues the postfix stream as one-cycle NUMBER/SIGN strobes to the
// stack evaluator, spaced by at least MIN_GAP idle cycles and held off by DOWN_BUSY.
// Each expression is closed by an end marker (both strobes, payload 8'h00).
//   CLK, RST : clock, synchronous active-high reset
//   bus      : infix_to_postfix_if.slave (token input, strobe outputs, sticky ERR)
// Parameters: STACK_DEPTH (operator stack entries, power of two >= 4), MIN_GAP.
// Optional feature macro: ITP_PAREN_EN enables '(' and ')'; otherwise they are
// unknown codes and raise ERR.
module infix_to_postfix
  import itp_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int MIN_GAP     = 2
) (
  input logic               CLK,
  input logic               RST,
  infix_to_postfix_if.slave bus
);
  localparam int GW = $clog2(MIN_GAP + 1) + 1;

  state_t        state;
  logic [7:0]    tok;
  logic          last_q;
  logic          in_ready, err;
  logic          number_stb, sign_stb;
  logic [7:0]    out_number, out_sign;
  logic [GW-1:0] idle_cnt;

  logic       st_push, st_pop, st_clr, st_empty, st_full;
  logic [7:0] st_push_data, st_top;

  logic fire, can_emit, red_pop, err_hit, err_last;
  logic emit_num, emit_sign, emit_end, drop_lp;
  logic in_lp, in_rp, top_lp;

  itp_op_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (st_clr),
    .push     (st_push),
    .pop      (st_pop),
    .push_data(st_push_data),
    .top      (st_top),
    .empty    (st_empty),
    .full     (st_full)
  );

`ifdef ITP_PAREN_EN
  assign in_lp  = !bus.IN_IS_NUM && (bus.IN_DATA == TOK_LPAREN);
  assign in_rp  = !bus.IN_IS_NUM && (bus.IN_DATA == TOK_RPAREN);
  assign top_lp = !st_empty && (st_top == TOK_LPAREN);
`else
  assign in_lp  = 1'b0;
  assign in_rp  = 1'b0;
  assign top_lp = 1'b0;
`endif

  // Per-cycle decisions shared by the stack controls and the state register.
  always_comb begin
    fire      = bus.IN_VALID && in_ready;
    // idle_cnt counts idle cycles since the last visible strobe; a decision
    // made now becomes visible next cycle.
    can_emit  = !bus.DOWN_BUSY && (idle_cnt >= GW'(MIN_GAP));
    red_pop   = !st_empty && (prec(st_top) >= prec(tok));
    err_last  = (state == ST_ACCEPT) ? bus.IN_LAST : last_q;
    err_hit   = 1'b0;
    emit_sign = 1'b0;
    drop_lp   = 1'b0;
    case (state)
      ST_ACCEPT: begin
        if (fire && !bus.IN_IS_NUM) begin
          if (in_lp)                                   err_hit = st_full;
          else if (!is_arith(bus.IN_DATA) && !in_rp)   err_hit = 1'b1;
        end
      end
      ST_REDUCE:  emit_sign = red_pop && can_emit;
      ST_PUSH_OP: err_hit   = st_full;
`ifdef ITP_PAREN_EN
      ST_CLOSE: begin
        if (st_empty)    err_hit   = 1'b1;
        else if (top_lp) drop_lp   = 1'b1;
        else             emit_sign = can_emit;
      end
`endif
      ST_DRAIN: begin
        if (top_lp) err_hit   = 1'b1;
        else        emit_sign = !st_empty && can_emit;
      end
      default: ;
    endcase
    emit_num     = (state == ST_EMIT_NUM) && can_emit;
    emit_end     = (state == ST_END_MARK) && can_emit;
    st_push      = ((state == ST_ACCEPT) && fire && in_lp && !st_full) ||
                   ((state == ST_PUSH_OP) && !st_full);
    st_push_data = (state == ST_ACCEPT) ? bus.IN_DATA : tok;
    st_pop       = emit_sign || drop_lp;
    st_clr       = err_hit || emit_end || ((state == ST_FLUSH) && fire && bus.IN_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_ACCEPT;
      tok        <= 8'h00;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      err        <= 1'b0;
      number_stb <= 1'b0;
      sign_stb   <= 1'b0;
      out_number <= 8'h00;
      out_sign   <= 8'h00;
      idle_cnt   <= '0;
    end else begin
      number_stb <= emit_num || emit_end;
      sign_stb   <= emit_sign || emit_end;
      if (emit_num)  out_number <= tok;
      if (emit_sign) out_sign   <= st_top;
      if (emit_end) begin
        out_number <= END_MARK_VAL;
        out_sign   <= END_MARK_VAL;
      end
      if (emit_num || emit_sign || emit_end) idle_cnt <= '0;
      else if (idle_cnt < GW'(MIN_GAP))      idle_cnt <= idle_cnt + 1'b1;

      in_ready <= 1'b0;
      if (err_hit) begin
        // If the offending token already closed the expression there is
        // nothing left to discard.
        err      <= 1'b1;
        state    <= err_last ? ST_ACCEPT : ST_FLUSH;
        in_ready <= 1'b1;
      end else begin
        case (state)
          ST_ACCEPT: begin
            in_ready <= 1'b1;
            if (fire) begin
              tok    <= bus.IN_DATA;
              last_q <= bus.IN_LAST;
              if (bus.IN_IS_NUM) begin
                state <= ST_EMIT_NUM; in_ready <= 1'b0;
              end else if (is_arith(bus.IN_DATA)) begin
                state <= ST_REDUCE;   in_ready <= 1'b0;
              end
`ifdef ITP_PAREN_EN
              else if (in_rp) begin
                state <= ST_CLOSE;    in_ready <= 1'b0;
              end else if (bus.IN_LAST) begin
                state <= ST_DRAIN;    in_ready <= 1'b0;  // '(' pushed as last token
              end
`endif
            end
          end
          ST_EMIT_NUM: begin
            if (emit_num) begin
              state    <= last_q ? ST_DRAIN : ST_ACCEPT;
              in_ready <= !last_q;
            end
          end
          ST_REDUCE: if (!red_pop) state <= ST_PUSH_OP;
          ST_PUSH_OP: begin
            state    <= last_q ? ST_DRAIN : ST_ACCEPT;
            in_ready <= !last_q;
          end
`ifdef ITP_PAREN_EN
          ST_CLOSE: begin
            if (drop_lp) begin
              state    <= last_q ? ST_DRAIN : ST_ACCEPT;
              in_ready <= !last_q;
            end
          end
`endif
          ST_DRAIN: if (st_empty) state <= ST_END_MARK;
          ST_END_MARK: begin
            if (emit_end) begin
              state    <= ST_ACCEPT;
              in_ready <= 1'b1;
            end
          end
          ST_FLUSH: begin
            in_ready <= 1'b1;
            if (fire && bus.IN_LAST) state <= ST_ACCEPT;
          end
          default: state <= ST_ACCEPT;
        endcase
      end
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.OUT_NUMBER = out_number;
  assign bus.NUMBER_STB = number_stb;
  assign bus.OUT_SIGN   = out_sign;
  assign bus.SIGN_STB   = sign_stb;
  assign bus.ERR        = err;
endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: table of expressions (digit chars are numbers,
// '.' in the expected string is the end marker), scoreboard queue of expected
// strobes checked by a negedge monitor, plus hand sequences for back-pressure,
// mid-expression reset, parentheses and stack overflow.
module tb_infix_to_postfix;
  localparam int STACK_DEPTH = 16;
  localparam int MIN_GAP     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  infix_to_postfix_if bus ();

  infix_to_postfix #(.STACK_DEPTH(STACK_DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    string in;
    string ex;
    bit    err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;
  int cyc = 0;
  int last_cyc = -1000;
  logic busy_q = 1'b0;
  bit [9:0] expq[$];
  bit [9:0] e_item, a_item;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // {kind, value}: kind 1 = number, 2 = operator, 3 = end marker
  function automatic bit [9:0] exp_of(input byte c);
    if (c >= "0" && c <= "9") return {2'd1, 8'(c - 8'h30)};
    if (c == ".")             return {2'd3, 8'h00};
    return {2'd2, 8'(c)};
  endfunction

  function automatic string kind_name(input bit [1:0] k);
    case (k)
      2'd1: return "NUM";
      2'd2: return "SIGN";
      2'd3: return "END";
      default: return "?";
    endcase
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= bus.DOWN_BUSY;
  end

  // Strobe monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      last_cyc = -1000;
    end else if (bus.NUMBER_STB || bus.SIGN_STB) begin
      n_strobes++;
      if (bus.NUMBER_STB && bus.SIGN_STB) a_item = {2'd3, bus.OUT_NUMBER | bus.OUT_SIGN};
      else if (bus.NUMBER_STB)            a_item = {2'd1, bus.OUT_NUMBER};
      else                                a_item = {2'd2, bus.OUT_SIGN};
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got %s 0x%0h expected nothing at cycle %0d",
                 kind_name(a_item[9:8]), a_item[7:0], cyc);
      end else begin
        e_item = expq.pop_front();
        chk({"out_", kind_name(e_item[9:8])}, int'(a_item), int'(e_item));
      end
      if (last_cyc > -1000) chk("min_gap_ok", int'((cyc - last_cyc - 1) >= MIN_GAP), 1);
      chk("busy_respected", int'(busy_q), 0);
      last_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_tok(input bit num, input logic [7:0] d, input bit last);
    int g = 0;
    @(negedge clk);
    bus.IN_VALID  = 1'b1;
    bus.IN_IS_NUM = num;
    bus.IN_DATA   = d;
    bus.IN_LAST   = last;
    while (!bus.IN_READY && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_for_token", int'(bus.IN_READY), 1);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit mark_last);
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      bit  num = (c >= "0" && c <= "9");
      send_tok(num, num ? 8'(c - 8'h30) : 8'(c), mark_last && (i == s.len() - 1));
    end
    idle_in();
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(exp_of(s[i]));
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while (expq.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_all_outputs"}, expq.size(), 0);
    expq.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
    expq.delete();
    repeat (2) @(negedge clk);
    chk("rst_in_ready",   int'(bus.IN_READY), 0);
    chk("rst_number_stb", int'(bus.NUMBER_STB), 0);
    chk("rst_sign_stb",   int'(bus.SIGN_STB), 0);
    chk("rst_out_number", int'(bus.OUT_NUMBER), 0);
    chk("rst_out_sign",   int'(bus.OUT_SIGN), 0);
    chk("rst_err",        int'(bus.ERR), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", int'(bus.IN_READY), 1);
  endtask

  task automatic run_vec(input vec_t v);
    push_exp(v.ex);
    send_str(v.in, 1'b1);
    wait_drain(v.name);
    chk({v.name, "_err"}, int'(bus.ERR), int'(v.err));
  endtask

  vec_t vecs[7];
  vec_t vp;
  string nest;
  int s0;

  initial begin
    bus.IN_VALID  = 1'b0;
    bus.IN_IS_NUM = 1'b0;
    bus.IN_DATA   = 8'h00;
    bus.IN_LAST   = 1'b0;
    bus.DOWN_BUSY = 1'b0;

    vecs[0] = '{"add",       "3+4",     "34+.",     1'b0};
    vecs[1] = '{"prec",      "2+3*4",   "234*+.",   1'b0};
    vecs[2] = '{"left_sub",  "8-3-2",   "83-2-.",   1'b0};
    vecs[3] = '{"left_muldiv","9/3*2",  "93/2*.",   1'b0};
    vecs[4] = '{"mul_first", "1*2+3",   "12*3+.",   1'b0};
    vecs[5] = '{"single",    "7",       "7.",       1'b0};
    vecs[6] = '{"mixed",     "6-4+1*2", "64-12*+.", 1'b0};

    do_reset();

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Full-range number payloads
    push_exp("");
    expq.push_back({2'd1, 8'd200});
    expq.push_back({2'd1, 8'd255});
    expq.push_back({2'd2, 8'h2D});
    expq.push_back({2'd3, 8'h00});
    send_tok(1'b1, 8'd200, 1'b0);
    send_tok(1'b0, 8'h2D,  1'b0);
    send_tok(1'b1, 8'd255, 1'b1);
    idle_in();
    wait_drain("wide_nums");

    // DOWN_BUSY held for 5 cycles mid-expression
    push_exp("234*+.");
    fork
      send_str("2+3*4", 1'b1);
      begin
        repeat (4) @(negedge clk);
        bus.DOWN_BUSY = 1'b1;
        repeat (5) @(negedge clk);
        bus.DOWN_BUSY = 1'b0;
      end
    join
    wait_drain("busy");
    chk("busy_err", int'(bus.ERR), 0);

    // Reset while a number is stalled by DOWN_BUSY: nothing may come out
    bus.DOWN_BUSY = 1'b1;
    send_tok(1'b1, 8'd9, 1'b0);
    idle_in();
    s0 = n_strobes;
    repeat (3) @(negedge clk);
    do_reset();
    bus.DOWN_BUSY = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_strobe_after_mid_rst", n_strobes - s0, 0);

    // Parentheses (error when the feature is compiled out)
`ifdef ITP_PAREN_EN
    vp = '{"paren", "(1+2)*3", "12+3*.", 1'b0};
`else
    vp = '{"paren", "(1+2)*3", "", 1'b1};
`endif
    run_vec(vp);

    // 17 nested '(' overflows a 16-deep stack; input drained to IN_LAST
    nest = "";
    for (int i = 0; i < STACK_DEPTH + 1; i++) nest = {nest, "("};
    nest = {nest, "1"};
    vp = '{"overflow", nest, "", 1'b1};
    run_vec(vp);
    chk("overflow_ready_after_flush", int'(bus.IN_READY), 1);

    do_reset();
    vp = '{"after_rst", "5*6", "56*.", 1'b0};
    run_vec(vp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
